// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph type, glyph constants and nibble encoder for the 7-segment scan controller
// Purpose: shared glyph definitions. Glyph bit order is {g,f,e,d,c,b,a}, 1 = segment lit.
// Ports: none (package).
package seg7_pkg;

   typedef logic [6:0] seg7_glyph_t;

   localparam seg7_glyph_t GLYPH_0     = 7'h3F;
   localparam seg7_glyph_t GLYPH_1     = 7'h06;
   localparam seg7_glyph_t GLYPH_2     = 7'h5B;
   localparam seg7_glyph_t GLYPH_3     = 7'h4F;
   localparam seg7_glyph_t GLYPH_4     = 7'h66;
   localparam seg7_glyph_t GLYPH_5     = 7'h6D;
   localparam seg7_glyph_t GLYPH_6     = 7'h7D;
   localparam seg7_glyph_t GLYPH_7     = 7'h07;
   localparam seg7_glyph_t GLYPH_8     = 7'h7F;
   localparam seg7_glyph_t GLYPH_9     = 7'h6F;
   localparam seg7_glyph_t GLYPH_A     = 7'h77;
   localparam seg7_glyph_t GLYPH_B     = 7'h7C;
   localparam seg7_glyph_t GLYPH_C     = 7'h39;
   localparam seg7_glyph_t GLYPH_D     = 7'h5E;
   localparam seg7_glyph_t GLYPH_E     = 7'h79;
   localparam seg7_glyph_t GLYPH_F     = 7'h71;
   localparam seg7_glyph_t GLYPH_DASH  = 7'h40;
   localparam seg7_glyph_t GLYPH_BLANK = 7'h00;

   // BCD mode has no letters: codes 10..15 render as a dash so bad data is visible.
   function automatic seg7_glyph_t seg7_encode(input logic [3:0] val, input logic hex_mode);
      seg7_glyph_t g;
      g = GLYPH_BLANK;
      case (val)
         4'h0: g = GLYPH_0;
         4'h1: g = GLYPH_1;
         4'h2: g = GLYPH_2;
         4'h3: g = GLYPH_3;
         4'h4: g = GLYPH_4;
         4'h5: g = GLYPH_5;
         4'h6: g = GLYPH_6;
         4'h7: g = GLYPH_7;
         4'h8: g = GLYPH_8;
         4'h9: g = GLYPH_9;
         4'hA: g = GLYPH_A;
         4'hB: g = GLYPH_B;
         4'hC: g = GLYPH_C;
         4'hD: g = GLYPH_D;
         4'hE: g = GLYPH_E;
         4'hF: g = GLYPH_F;
         default: g = GLYPH_BLANK;
      endcase
      if (!hex_mode && (val > 4'd9)) begin
         g = GLYPH_DASH;
      end
      return g;
   endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - combinational nibble to 7-segment glyph lookup
// Purpose: converts one digit value to its segment pattern, or blank when suppressed.
// Ports:
//   nibble   in  4  digit value
//   hex_mode in  1  1: 0-F glyphs, 0: BCD with dash for 10-15
//   blank    in  1  force all segments a-g off
//   glyph    out 7  {g,f,e,d,c,b,a}, 1 = lit
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0]  nibble,
   input  logic        hex_mode,
   input  logic        blank,
   output seg7_glyph_t glyph
);

   always_comb begin
      glyph = GLYPH_BLANK;
      if (!blank) begin
         glyph = seg7_encode(nibble, hex_mode);
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed N-digit 7-segment scan controller
// Purpose: double-buffered digit data, scan/slot counters with dead-time, PWM brightness,
//          blink, leading-zero suppression and registered pin outputs.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   valid                     load strobe for digit_data/dp_mask/blink_mask
//   digit_data [4*N_DIGITS]   digit i at [4i+3:4i], digit 0 rightmost
//   dp_mask, blink_mask [N]   per-digit decimal point and blink enable
//   hex_mode, lz_suppress     glyph mode, leading-zero blanking
//   brightness [BRIGHT_W]     0 = dark, all-ones = full on
//   enable                    0 blanks the display, counters keep running
//   seg [8]                   {dp,g,f,e,d,c,b,a}
//   an [N_DIGITS]             one-hot digit select
//   frame_start               1-cycle pulse at start of the digit-0 slot
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int SLOT_CYCLES    = 1000,
   parameter int BRIGHT_W       = 3,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic [4*N_DIGITS-1:0] digit_data,
   input  logic [N_DIGITS-1:0]   dp_mask,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic                  hex_mode,
   input  logic                  lz_suppress,
   input  logic [BRIGHT_W-1:0]   brightness,
   input  logic                  enable,
   output logic [7:0]            seg,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_start
);

   localparam int SLOT_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W  = $clog2(N_DIGITS);
   localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [7:0]          SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [N_DIGITS-1:0] AN_INV    = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

   logic [SLOT_W-1:0]     slot_cnt;
   logic [IDX_W-1:0]      scan_idx;
   logic [BRIGHT_W-1:0]   pwm_cnt;
   logic [BLK_W-1:0]      blink_cnt;
   logic                  blink_phase;

   logic [4*N_DIGITS-1:0] pend_data, act_data;
   logic [N_DIGITS-1:0]   pend_dp, act_dp;
   logic [N_DIGITS-1:0]   pend_blink, act_blink;

   logic                  frame_bound;
   logic                  frame_end;
   logic [N_DIGITS-1:0]   lz_blank;
   logic                  zeros_above;
   logic [3:0]            cur_nibble;
   seg7_glyph_t           cur_glyph;
   logic                  pwm_on;
   logic                  lit;
   logic [7:0]            seg_nxt;
   logic [N_DIGITS-1:0]   an_nxt;

   assign frame_bound = (slot_cnt == '0) && (scan_idx == '0);
   assign frame_end   = (slot_cnt == SLOT_LAST) && (scan_idx == IDX_LAST);

   // Scan, PWM and blink counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt    <= '0;
         scan_idx    <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
         // Counting completed frames keeps the first BLINK_FRAMES frames after reset in phase 0.
         if (frame_end) begin
            if (blink_cnt == BLK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // Double buffer: the active copy only changes on the frame boundary cycle, which is
   // itself a dead-time cycle, so a frame is always rendered from one coherent snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blink <= '0;
         act_data   <= '0;
         act_dp     <= '0;
         act_blink  <= '0;
      end else begin
         if (valid) begin
            pend_data  <= digit_data;
            pend_dp    <= dp_mask;
            pend_blink <= blink_mask;
         end
         if (frame_bound) begin
            act_data  <= valid ? digit_data : pend_data;
            act_dp    <= valid ? dp_mask    : pend_dp;
            act_blink <= valid ? blink_mask : pend_blink;
         end
      end
   end

   // A digit is blanked when it and every more significant digit is zero; digit 0 never is.
   always_comb begin
      lz_blank    = '0;
      zeros_above = 1'b1;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         zeros_above = zeros_above && (act_data[4*i +: 4] == 4'd0);
         lz_blank[i] = lz_suppress && zeros_above;
      end
   end

   assign cur_nibble = act_data[4*scan_idx +: 4];

   seg7_glyph_rom u_glyph_rom (
      .nibble   (cur_nibble),
      .hex_mode (hex_mode),
      .blank    (lz_blank[scan_idx]),
      .glyph    (cur_glyph)
   );

   assign pwm_on = (pwm_cnt < brightness) || (&brightness);

   // slot_cnt==0 is the anti-ghost gap between digits; seg follows an so nothing is driven
   // while no digit is selected.
   always_comb begin
      lit     = enable && (slot_cnt != '0) && pwm_on && !(blink_phase && act_blink[scan_idx]);
      seg_nxt = 8'h00;
      an_nxt  = '0;
      if (lit) begin
         seg_nxt = {act_dp[scan_idx], cur_glyph};
         an_nxt  = N_DIGITS'(1) << scan_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg         <= SEG_INV;
         an          <= AN_INV;
         frame_start <= 1'b0;
      end else begin
         seg         <= seg_nxt ^ SEG_INV;
         an          <= an_nxt ^ AN_INV;
         frame_start <= frame_bound;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int SLOT  = 8;
   localparam int BW    = 2;
   localparam int BLINK = 2;
   localparam int FRAME = SLOT * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic [15:0]   digit_data = '0;
   logic [3:0]    dp_mask = '0;
   logic [3:0]    blink_mask = '0;
   logic          hex_mode = 1'b1;
   logic          lz_suppress = 1'b0;
   logic [BW-1:0] brightness = 2'd3;
   logic          enable = 1'b1;
   logic [7:0]    seg;
   logic [3:0]    an;
   logic          frame_start;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .N_DIGITS       (N),
      .SLOT_CYCLES    (SLOT),
      .BRIGHT_W       (BW),
      .BLINK_FRAMES   (BLINK),
      .SEG_ACTIVE_LOW (0),
      .AN_ACTIVE_LOW  (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (valid),
      .digit_data  (digit_data),
      .dp_mask     (dp_mask),
      .blink_mask  (blink_mask),
      .hex_mode    (hex_mode),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .enable      (enable),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   int total = 0;
   int bad = 0;
   int lit_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // {g,f,e,d,c,b,a}
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] an;
      logic       fs;
   } exp_t;

   exp_t q[$];

   int          t;
   logic [15:0] m_pdata, m_adata;
   logic [3:0]  m_pdp, m_adp, m_pblk, m_ablk;

   task automatic model_reset();
      t = 0;
      m_pdata = '0; m_adata = '0;
      m_pdp = '0;   m_adp = '0;
      m_pblk = '0;  m_ablk = '0;
      q.delete();
   endtask

   // Reference: everything derived from the cycle number since reset.
   function automatic exp_t model_out();
      exp_t       e;
      int         slot, idx, frame;
      logic       phase, lit;
      logic [1:0] pwm;
      logic [3:0] nib;
      logic [6:0] g;
      slot  = t % SLOT;
      idx   = (t / SLOT) % N;
      frame = t / FRAME;
      phase = ((frame / BLINK) % 2) == 1;
      pwm   = 2'(t % 4);
      e.fs  = (t % FRAME) == 0;
      e.seg = 8'h00;
      e.an  = 4'h0;
      lit = enable && (slot != 0) && ((pwm < brightness) || (brightness == 2'd3)) && !(phase && m_ablk[idx]);
      if (lit) begin
         nib = m_adata[idx*4 +: 4];
         g = (!hex_mode && nib > 4'd9) ? 7'h40 : hex_tab[nib];
         if (lz_suppress && idx > 0 && (m_adata >> (idx*4)) == 16'h0) g = 7'h00;
         e.an  = 4'(1 << idx);
         e.seg = {m_adp[idx], g};
      end
      return e;
   endfunction

   task automatic model_update();
      if ((t % FRAME) == 0) begin
         m_adata = valid ? digit_data : m_pdata;
         m_adp   = valid ? dp_mask    : m_pdp;
         m_ablk  = valid ? blink_mask : m_pblk;
      end
      if (valid) begin
         m_pdata = digit_data;
         m_pdp   = dp_mask;
         m_pblk  = blink_mask;
      end
      t++;
   endtask

   // Called at a negedge with inputs settled: push the expectation, clock once, pop and compare.
   task automatic step();
      exp_t e;
      int   tc;
      tc = t;
      q.push_back(model_out());
      model_update();
      @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      check($sformatf("seg@%0d", tc), 32'(seg), 32'(e.seg));
      check($sformatf("an@%0d", tc), 32'(an), 32'(e.an));
      check($sformatf("frame_start@%0d", tc), 32'(frame_start), 32'(e.fs));
      if (an != 4'h0) lit_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
      digit_data = d;
      dp_mask    = dp;
      blink_mask = bm;
      valid      = 1'b1;
      step();
      valid      = 1'b0;
   endtask

   task automatic run_to_frame();
      while ((t % FRAME) != 0) step();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check("reset_seg", 32'(seg), 32'h0);
      check("reset_an", 32'(an), 32'h0);
      check("reset_fs", 32'(frame_start), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: basic scan of 0x1234, loaded on the boundary cycle
      load(16'h1234, 4'h0, 4'h0);
      run(2 * FRAME - 1);

      // 2: mid-frame load stays invisible until the next frame
      run(10);
      load(16'h9876, 4'h0, 4'h0);
      run_to_frame();
      run(2 * FRAME);

      // 3: BCD dash and leading-zero blanking, then hex letter
      hex_mode = 1'b0;
      lz_suppress = 1'b1;
      load(16'h00A5, 4'h0, 4'h0);
      run_to_frame();
      run(FRAME);
      hex_mode = 1'b1;
      run(FRAME);
      lz_suppress = 1'b0;

      // 4: brightness duty
      brightness = 2'd1;
      lit_cnt = 0;
      run(FRAME);
      check("bright1_lit", lit_cnt, 4);
      brightness = 2'd2;
      lit_cnt = 0;
      run(FRAME);
      check("bright2_lit", lit_cnt, 12);
      brightness = 2'd0;
      lit_cnt = 0;
      run(FRAME);
      check("bright0_lit", lit_cnt, 0);
      brightness = 2'd3;

      // enable low blanks the pins but frame_start keeps pulsing
      enable = 1'b0;
      lit_cnt = 0;
      run(FRAME);
      check("disabled_lit", lit_cnt, 0);
      enable = 1'b1;

      // 5: blink on digit 1, decimal point on digit 2
      load(16'h1234, 4'b0100, 4'b0010);
      run(8 * FRAME);

      // 6: asynchronous reset in the middle of a lit slot
      while ((t % SLOT) != 3) step();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_seg", 32'(seg), 32'h0);
      check("async_rst_an", 32'(an), 32'h0);
      check("async_rst_fs", 32'(frame_start), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("held_rst_an", 32'(an), 32'h0);
      rst_n = 1'b1;
      model_reset();
      load(16'h4321, 4'h0, 4'h0);
      run(FRAME + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
